mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Burst arbiter between instruction and data caches onto one main memory.
// Data wins ties, but a waiting instruction fetch is served after a bounded run of data grants.
`ifndef MEM_NOP
`define MEM_NOP           2'd0
`define MEM_READ          2'd1
`define MEM_WRITE         2'd2
`endif
`ifndef MEM_RESTING
`define MEM_RESTING       2'd0
`define MEM_INST_FINISHED 2'd1
`define MEM_DATA_FINISHED 2'd2
`endif
`ifndef ONE_BYTE
`define ONE_BYTE          3'd1
`define TWO_BYTE          3'd2
`define FOUR_BYTE         3'd4
`endif

module mem_arbiter #(
  parameter int ADDR_WIDTH       = 17,
  parameter int DATA_LEN         = 32,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic [ENTRY_INDEX_SIZE:0] i_len,
  output logic [DATA_LEN-1:0]       i_rdata,
  output logic                      i_rvalid,
  output logic                      i_done,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDR_WIDTH-1:0]     d_addr,
  input  logic [ENTRY_INDEX_SIZE:0] d_len,
  input  logic [2:0]                d_data_type,
  input  logic [DATA_LEN-1:0]       d_wdata,
  output logic                      d_wready,
  output logic [DATA_LEN-1:0]       d_rdata,
  output logic                      d_rvalid,
  output logic                      d_done,
  output logic                      err,
  output logic [1:0]                mem_i_signal,
  output logic [1:0]                mem_d_signal,
  output logic [ADDR_WIDTH-1:0]     mem_i_addr,
  output logic [ADDR_WIDTH-1:0]     mem_d_addr,
  output logic [DATA_LEN-1:0]       mem_wdata,
  output logic [2:0]                mem_data_type,
  input  logic [DATA_LEN-1:0]       mem_rdata,
  input  logic [1:0]                mem_status
);

  localparam int LW = ENTRY_INDEX_SIZE + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE, I_BURST, D_RD_BURST, D_WR_BURST, DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [2:0]            type_q, type_d;
  logic                  own_i_q, own_i_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  err_q, err_d;
  logic                  rsp_q, rsp_d;
  logic                  rsp_i_q, rsp_i_d;

  logic                  grant_i, grant_d, last;
  logic [ADDR_WIDTH-1:0] beat_addr;

  function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] l);
    return (l == '0) ? LW'(1) : l;
  endfunction

  assign grant_i   = i_req && (!d_req || starve_q >= SLIM);
  assign grant_d   = d_req && !grant_i;
  assign last      = (cnt_q == len_q - 1'b1);
  assign beat_addr = base_q + (ADDR_WIDTH'(cnt_q) << 2);
  assign err       = err_q;

  // Arbitration, beat sequencing, memory commands and read-return routing
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    own_i_d  = own_i_q;
    starve_d = starve_q;
    err_d    = err_q;
    rsp_d    = 1'b0;
    rsp_i_d  = rsp_i_q;
    i_rdata       = '0;
    i_rvalid      = 1'b0;
    i_done        = 1'b0;
    d_rdata       = '0;
    d_rvalid      = 1'b0;
    d_done        = 1'b0;
    d_wready      = 1'b0;
    mem_i_signal  = `MEM_NOP;
    mem_d_signal  = `MEM_NOP;
    mem_i_addr    = '0;
    mem_d_addr    = '0;
    mem_wdata     = '0;
    mem_data_type = '0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant_i: begin
            state_d  = I_BURST;
            base_d   = i_addr;
            len_d    = eff_len(i_len);
            cnt_d    = '0;
            own_i_d  = 1'b1;
            starve_d = '0;
          end
          grant_d: begin
            state_d = d_we ? D_WR_BURST : D_RD_BURST;
            base_d  = d_addr;
            len_d   = (d_data_type != `FOUR_BYTE) ?
                      LW'(1) : eff_len(d_len);
            cnt_d   = '0;
            type_d  = d_data_type;
            own_i_d = 1'b0;
            if (i_req && starve_q != SLIM)
              starve_d = starve_q + 1'b1;
          end
          default: ;
        endcase
      end
      I_BURST: begin
        mem_i_signal = `MEM_READ;
        mem_i_addr   = beat_addr;
        rsp_d        = 1'b1;
        rsp_i_d      = 1'b1;
        cnt_d        = cnt_q + 1'b1;
        if (last) state_d = DRAIN;
      end
      D_RD_BURST: begin
        mem_d_signal = `MEM_READ;
        mem_i_addr   = beat_addr;
        rsp_d        = 1'b1;
        rsp_i_d      = 1'b0;
        cnt_d        = cnt_q + 1'b1;
        if (last) state_d = DRAIN;
      end
      D_WR_BURST: begin
        mem_d_signal  = `MEM_WRITE;
        mem_d_addr    = beat_addr;
        mem_wdata     = d_wdata;
        mem_data_type = type_q;
        d_wready      = 1'b1;
        cnt_d         = cnt_q + 1'b1;
        if (last) state_d = DRAIN;
      end
      DRAIN: begin
        i_done  = own_i_q;
        d_done  = !own_i_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rsp_q) begin
      if (rsp_i_q) begin
        if (mem_status == `MEM_INST_FINISHED) begin
          i_rvalid = 1'b1;
          i_rdata  = mem_rdata;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        if (mem_status == `MEM_DATA_FINISHED) begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // State and burst context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      type_q   <= '0;
      own_i_q  <= 1'b0;
      starve_q <= '0;
      err_q    <= 1'b0;
      rsp_q    <= 1'b0;
      rsp_i_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      own_i_q  <= own_i_d;
      starve_q <= starve_d;
      err_q    <= err_d;
      rsp_q    <= rsp_d;
      rsp_i_q  <= rsp_i_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level schedule model,
// directed corner bursts, random traffic and a mid-burst reset.
`ifndef MEM_NOP
`define MEM_NOP           2'd0
`define MEM_READ          2'd1
`define MEM_WRITE         2'd2
`endif
`ifndef MEM_RESTING
`define MEM_RESTING       2'd0
`define MEM_INST_FINISHED 2'd1
`define MEM_DATA_FINISHED 2'd2
`endif
`ifndef ONE_BYTE
`define ONE_BYTE          3'd1
`define TWO_BYTE          3'd2
`define FOUR_BYTE         3'd4
`endif

module tb_mem_arbiter;
  localparam int AW = 17;
  localparam int DL = 32;
  localparam int EI = 3;
  localparam int SL = 4;

  logic          clk, rst_n;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [EI:0]   i_len, d_len;
  logic [2:0]    d_data_type;
  logic [DL-1:0] d_wdata, mem_rdata;
  logic [1:0]    mem_status;
  logic [DL-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_rvalid, i_done, d_wready, d_rvalid, d_done, err;
  logic [1:0]    mem_i_signal, mem_d_signal;
  logic [AW-1:0] mem_i_addr, mem_d_addr;
  logic [2:0]    mem_data_type;

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_LEN(DL),
    .ENTRY_INDEX_SIZE(EI), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len),
    .d_data_type(d_data_type), .d_wdata(d_wdata),
    .d_wready(d_wready), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .d_done(d_done), .err(err),
    .mem_i_signal(mem_i_signal), .mem_d_signal(mem_d_signal),
    .mem_i_addr(mem_i_addr), .mem_d_addr(mem_d_addr),
    .mem_wdata(mem_wdata), .mem_data_type(mem_data_type),
    .mem_rdata(mem_rdata), .mem_status(mem_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_pass;
  int t, free_at, starve;
  bit merr, i_fin, d_fin;

  // expected per-cycle activity, keyed by cycle number
  int e_isig[int], e_dsig[int], e_iaddr[int], e_daddr[int];
  int e_type[int], e_rsp[int];
  bit e_wr[int], e_idone[int], e_ddone[int];

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h want %0h",
                  tag, t, obs, exp);
  endtask

  function automatic int eff_len(input int l, input bit isd,
                                 input int typ);
    int r;
    r = (l == 0) ? 1 : l;
    if (isd && typ != int'(`FOUR_BYTE)) r = 1;
    return r;
  endfunction

  task automatic model_clear();
    e_isig.delete(); e_dsig.delete(); e_iaddr.delete();
    e_daddr.delete(); e_type.delete(); e_rsp.delete();
    e_wr.delete(); e_idone.delete(); e_ddone.delete();
  endtask

  // grant decision and schedule of the whole burst at once
  task automatic model_grant();
    int len, base, kind, c, a;
    bit gi;
    if (!rst_n || t < free_at || !(i_req || d_req)) return;
    gi = i_req && (!d_req || starve >= SL);
    if (gi) begin
      len = eff_len(int'(i_len), 0, 0);
      base = int'(i_addr); kind = 0; starve = 0;
    end else begin
      len = eff_len(int'(d_len), 1, int'(d_data_type));
      base = int'(d_addr); kind = d_we ? 2 : 1;
      if (i_req && starve < SL) starve++;
    end
    for (int k = 0; k < len; k++) begin
      c = t + 1 + k;
      a = (base + 4 * k) % (1 << AW);
      if (kind == 0) begin
        e_isig[c] = int'(`MEM_READ); e_iaddr[c] = a;
        e_rsp[c + 1] = 1;
      end else if (kind == 1) begin
        e_dsig[c] = int'(`MEM_READ); e_iaddr[c] = a;
        e_rsp[c + 1] = 2;
      end else begin
        e_dsig[c] = int'(`MEM_WRITE); e_daddr[c] = a;
        e_wr[c] = 1'b1; e_type[c] = int'(d_data_type);
      end
    end
    if (kind == 0) e_idone[t + 1 + len] = 1'b1;
    else           e_ddone[t + 1 + len] = 1'b1;
    free_at = t + len + 2;
  endtask

  // one clock: drive memory side, check all outputs, update model
  task automatic step();
    int own;
    bit iv, dv, wr;
    logic [1:0] good;
    mem_rdata = $urandom;
    d_wdata   = $urandom;
    own = e_rsp.exists(t) ? e_rsp[t] : 0;
    good = (own == 1) ? `MEM_INST_FINISHED :
           (own == 2) ? `MEM_DATA_FINISHED : `MEM_RESTING;
    mem_status = ($urandom % 8 == 0) ? 2'($urandom % 3) : good;
    #1;
    iv = (own == 1) && (mem_status == `MEM_INST_FINISHED);
    dv = (own == 2) && (mem_status == `MEM_DATA_FINISHED);
    wr = e_wr.exists(t);
    check("mem_i_signal", 64'(mem_i_signal),
          64'(e_isig.exists(t) ? e_isig[t] : 0));
    check("mem_d_signal", 64'(mem_d_signal),
          64'(e_dsig.exists(t) ? e_dsig[t] : 0));
    check("mem_i_addr", 64'(mem_i_addr),
          64'(e_iaddr.exists(t) ? e_iaddr[t] : 0));
    check("mem_d_addr", 64'(mem_d_addr),
          64'(e_daddr.exists(t) ? e_daddr[t] : 0));
    check("mem_wdata", 64'(mem_wdata), wr ? 64'(d_wdata) : 64'd0);
    check("mem_data_type", 64'(mem_data_type),
          64'(e_type.exists(t) ? e_type[t] : 0));
    check("d_wready", 64'(d_wready), 64'(wr));
    check("i_rvalid", 64'(i_rvalid), 64'(iv));
    check("i_rdata", 64'(i_rdata), iv ? 64'(mem_rdata) : 64'd0);
    check("d_rvalid", 64'(d_rvalid), 64'(dv));
    check("d_rdata", 64'(d_rdata), dv ? 64'(mem_rdata) : 64'd0);
    check("i_done", 64'(i_done), 64'(e_idone.exists(t)));
    check("d_done", 64'(d_done), 64'(e_ddone.exists(t)));
    check("err", 64'(err), 64'(merr));
    if (rst_n && own != 0 && !(iv || dv)) merr = 1'b1;
    i_fin = e_idone.exists(t);
    d_fin = e_ddone.exists(t);
    model_grant();
    @(negedge clk);
    t++;
  endtask

  // hold current requests until each completes
  task automatic run_reqs(input int bound);
    int n;
    n = 0;
    while ((i_req || d_req) && n < bound) begin
      step();
      if (i_fin) i_req = 1'b0;
      if (d_fin) d_req = 1'b0;
      n++;
    end
    if (i_req || d_req) begin
      check("timeout", 64'(1), 64'(0));
      i_req = 1'b0; d_req = 1'b0;
    end
  endtask

  task automatic idle_to_free();
    int n;
    n = 0;
    while (t < free_at && n < 40) begin
      step(); n++;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = AW'($urandom);
    if ($urandom % 4 == 0) a = AW'(17'h1FFFC - 4 * ($urandom % 3));
    return a;
  endfunction

  function automatic logic [2:0] rand_type();
    int r;
    r = $urandom % 4;
    return (r == 0) ? `ONE_BYTE : (r == 1) ? `TWO_BYTE : `FOUR_BYTE;
  endfunction

  initial begin
    n_chk = 0; n_pass = 0;
    t = 0; free_at = 0; starve = 0; merr = 1'b0;
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0; i_len = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_len = '0;
    d_data_type = '0; d_wdata = '0;
    mem_rdata = '0; mem_status = `MEM_RESTING;
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    free_at = t;

    i_req = 1'b1; i_addr = AW'(17'h100); i_len = 4'd4;
    run_reqs(20);
    idle_to_free();

    d_req = 1'b1; d_we = 1'b1; d_addr = AW'(17'h1FFFC);
    d_len = 4'd2; d_data_type = `FOUR_BYTE;
    run_reqs(20);
    idle_to_free();

    d_req = 1'b1; d_we = 1'b1; d_addr = AW'(17'h40);
    d_len = 4'd8; d_data_type = `ONE_BYTE;
    run_reqs(20);
    idle_to_free();

    i_req = 1'b1; i_addr = AW'(17'h200); i_len = 4'd0;
    d_req = 1'b1; d_we = 1'b0; d_addr = AW'(17'h300);
    d_len = 4'd2; d_data_type = `FOUR_BYTE;
    run_reqs(40);
    idle_to_free();

    for (int c = 0; c < 1200; c++) begin
      if (i_fin) i_req = 1'b0;
      if (d_fin) d_req = 1'b0;
      if (!i_req && $urandom % 4 == 0) begin
        i_req = 1'b1; i_addr = rand_addr(); i_len = 4'($urandom);
      end
      if (!d_req && $urandom % 4 != 0) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = rand_addr();
        d_len = 4'($urandom); d_data_type = rand_type();
      end
      step();
    end
    run_reqs(200);
    idle_to_free();

    i_req = 1'b1; i_addr = AW'(17'h500); i_len = 4'd4;
    step();
    step();
    step();
    rst_n = 1'b0;
    i_req = 1'b0;
    model_clear();
    merr = 1'b0; starve = 0;
    step();
    step();
    rst_n = 1'b1;
    free_at = t;
    for (int c = 0; c < 4; c++) step();
    i_req = 1'b1; i_addr = AW'(17'h40); i_len = 4'd2;
    run_reqs(20);
    idle_to_free();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
